adder_arb: RTL



---
 rtl/adder_pkg.sv | 10 +
 rtl/adder.sv | 12 +
 rtl/adder_arb.sv | 91 +++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared types and widths for the adder arbiter slice.
package adder_pkg;

  localparam int ADDER_W = 4;

  typedef enum logic [1:0] {IDLE, CALC, RESP} arb_state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/adder.sv
// Combinational W-bit adder; the carry-out is discarded.
module adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] q
);

  assign q = a + b;

endmodule

// File: rtl/adder_arb.sv
// Two-requester round-robin arbiter that serialises operand pairs onto one adder
// and returns each tagged sum over a valid/ready response channel.
import adder_pkg::*;

module adder_arb #(
  parameter int W = ADDER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_i,
  input  logic [W-1:0] a0_i,
  input  logic [W-1:0] b0_i,
  input  logic [W-1:0] a1_i,
  input  logic [W-1:0] b1_i,
  output logic [1:0]   gnt_o,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [W-1:0] rsp_q_o,
  output logic         rsp_id_o,
  output logic         busy_o,
  output logic [1:0]   state_dbg
);

  // Handshake: a response transfers on a rising edge where rsp_valid_o and
  // rsp_ready_i are both high; rsp_q_o/rsp_id_o hold while valid is waiting.

  arb_state_t     state;
  req_id_t        prio;
  req_id_t        cur_id;
  req_id_t        win;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;
  logic [W-1:0]   sum;

  // A lone requester always wins; under contention the pointer decides.
  assign win       = (req_i == 2'b11) ? prio : req_i[1];
  assign state_dbg = state;

  adder #(.W(W)) u_adder (
    .a (op_a),
    .b (op_b),
    .q (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      prio        <= 1'b0;
      cur_id      <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      gnt_o       <= 2'b00;
      rsp_valid_o <= 1'b0;
      rsp_q_o     <= '0;
      rsp_id_o    <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i != 2'b00) begin
            op_a   <= win ? a1_i : a0_i;
            op_b   <= win ? b1_i : b0_i;
            cur_id <= win;
            prio   <= ~win;
            gnt_o  <= win ? 2'b10 : 2'b01;
            busy_o <= 1'b1;
            state  <= CALC;
          end
        end
        CALC: begin
          rsp_q_o     <= sum;
          rsp_id_o    <= cur_id;
          rsp_valid_o <= 1'b1;
          gnt_o       <= 2'b00;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
